// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential M-extension unit.
//   md_op_e    : funct3 encoding of the mul/div operations
//   md_state_e : control FSM states
//   ALU_GRP_*  : alu_op[4:2] group codes for the mul and div families
//   op_*       : per-operation decode helpers (group, signedness, result select)
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  localparam logic [2:0] ALU_GRP_MUL = 3'b100;
  localparam logic [2:0] ALU_GRP_DIV = 3'b101;

  function automatic logic [2:0] op_group(input md_op_e op);
    return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) ? ALU_GRP_DIV : ALU_GRP_MUL;
  endfunction

  function automatic logic op_is_div(input md_op_e op);
    return op_group(op) == ALU_GRP_DIV;
  endfunction

  // High-half multiplies always run full width, even for word ops.
  function automatic logic op_is_mulh(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_MULHU};
  endfunction

  function automatic logic op_is_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  function automatic logic op_signed_a(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_signed_b(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder (always < divisor)
//   divisor : divisor magnitude
//   bit_in  : next dividend bit, MSB first
//   rem_out : updated partial remainder
//   q_bit   : quotient bit produced by this step
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] divisor,
  input  logic         bit_in,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // shifted < 2*divisor, so a non-negative trial always fits in W bits and
  // trial[W] alone tells whether the subtraction borrowed.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[W];
    rem_out = q_bit ? trial[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RISC-V M-extension unit (multiply, divide, remainder).
//   clock  : rising-edge clock
//   reset  : synchronous, active-low reset
//   start  : launch request, sampled only while idle
//   kill   : synchronous abort, wins over start
//   op     : funct3 (MUL..REMU)
//   s_32   : RV64 word op (ignored when XLEN=32 and for MULH*)
//   rs1    : operand A (multiplicand / dividend)
//   rs2    : operand B (multiplier / divisor)
//   busy   : unit not idle
//   done   : one-cycle pulse, result valid
//   result : registered result, held until the next done
// Operands are reduced to magnitudes at launch; signs are reapplied in FIX.
// Divide-by-zero, signed overflow and disabled divides skip CALC entirely.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_DIV = 1'b1,
  parameter int unsigned MUL_UNROLL = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic            s_32,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  md_state_e state_q, state_d;
  md_op_e    op_in;

  // launch-side decode
  logic            w32_in, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
  logic            ovf_in, fast_in;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_w, fast_val;
  logic [CW-1:0]   n_in;

  // FSM outputs
  logic launch, calc_step, load_res;

  // latched operation
  md_op_e          op_q;
  logic            w32_q, fast_q, neg_q, neg_r_q;
  logic [XLEN-1:0] fast_res_q;
  logic [CW-1:0]   cnt_q;

  // multiplier datapath
  logic [2*XLEN-1:0] acc_q, mcand_q, acc_n, mc_n;
  logic [XLEN-1:0]   mplier_q, mp_n;

  // divider datapath: dvd_q shifts dividend bits out of the top and
  // quotient bits in at the bottom, so it ends up holding the quotient
  logic [XLEN-1:0] rem_q, dvs_q, dvd_q, rem_n;
  logic            q_bit;

  // result fix-up
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_raw, fix_val;

  assign op_in = md_op_e'(op);

  always_comb begin : prep
    w32_in   = (XLEN == 64) && s_32 && !op_is_mulh(op_in);
    sgn_a_in = op_signed_a(op_in);
    sgn_b_in = op_signed_b(op_in);
    a_ext    = rs1;
    b_ext    = rs2;
    min_w    = {1'b1, {(XLEN-1){1'b0}}};
    if (w32_in) begin
      a_ext = sgn_a_in ? XLEN'($signed(rs1[31:0])) : XLEN'(rs1[31:0]);
      b_ext = sgn_b_in ? XLEN'($signed(rs2[31:0])) : XLEN'(rs2[31:0]);
      min_w = XLEN'(32'sh8000_0000);
    end
    neg_a_in = sgn_a_in & a_ext[XLEN-1];
    neg_b_in = sgn_b_in & b_ext[XLEN-1];
    mag_a    = neg_a_in ? -a_ext : a_ext;
    mag_b    = neg_b_in ? -b_ext : b_ext;

    ovf_in  = (op_in inside {MD_DIV, MD_REM}) && (a_ext == min_w) && (b_ext == '1);
    fast_in = op_is_div(op_in) && (!ENABLE_DIV || (b_ext == '0) || ovf_in);

    if (!ENABLE_DIV)
      fast_val = '0;
    else if (b_ext == '0)
      fast_val = op_is_rem(op_in) ? a_ext : '1;
    else
      fast_val = op_is_rem(op_in) ? '0 : a_ext;

    if (op_is_div(op_in))
      n_in = w32_in ? CW'(32) : CW'(XLEN);
    else
      n_in = w32_in ? CW'(32 / MUL_UNROLL) : CW'(XLEN / MUL_UNROLL);
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !kill) state_d = fast_in ? S_FIX : S_CALC;
      S_CALC: begin
        if (kill)                  state_d = S_IDLE;
        else if (cnt_q == CW'(1))  state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    busy      = (state_q != S_IDLE);
    launch    = (state_q == S_IDLE) && start && !kill;
    calc_step = (state_q == S_CALC) && !kill;
    load_res  = (state_q == S_FIX) && !kill;
  end

  // ---------------- iteration logic ----------------
  always_comb begin : mul_iter
    acc_n = acc_q;
    mc_n  = mcand_q;
    mp_n  = mplier_q;
    for (int unsigned i = 0; i < MUL_UNROLL; i++) begin
      if (mp_n[0]) acc_n = acc_n + mc_n;
      mc_n = mc_n << 1;
      mp_n = mp_n >> 1;
    end
  end

  div_step #(.W(XLEN)) u_div_step (
    .rem_in  (rem_q),
    .divisor (dvs_q),
    .bit_in  (dvd_q[XLEN-1]),
    .rem_out (rem_n),
    .q_bit   (q_bit)
  );

  always_comb begin : fix
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -dvd_q : dvd_q;
    rmd  = neg_r_q ? -rem_q : rem_q;
    if (fast_q)
      fix_raw = fast_res_q;
    else if (op_is_div(op_q))
      fix_raw = op_is_rem(op_q) ? rmd : quo;
    else if (op_q == MD_MUL)
      fix_raw = prod[XLEN-1:0];
    else
      fix_raw = prod[2*XLEN-1:XLEN];
    fix_val = w32_q ? XLEN'($signed(fix_raw[31:0])) : fix_raw;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      done       <= 1'b0;
      result     <= '0;
      op_q       <= MD_MUL;
      w32_q      <= 1'b0;
      fast_q     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r_q    <= 1'b0;
      fast_res_q <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      dvd_q      <= '0;
    end else begin
      done <= load_res;
      if (load_res) result <= fix_val;

      if (launch) begin
        op_q       <= op_in;
        w32_q      <= w32_in;
        fast_q     <= fast_in;
        fast_res_q <= fast_val;
        neg_q      <= neg_a_in ^ neg_b_in;
        neg_r_q    <= neg_a_in;
        cnt_q      <= n_in;
        acc_q      <= '0;
        mcand_q    <= {{XLEN{1'b0}}, mag_a};
        mplier_q   <= mag_b;
        rem_q      <= '0;
        dvs_q      <= mag_b;
        // word dividends are left-aligned so the first step sees bit 31
        dvd_q      <= w32_in ? (mag_a << (XLEN - 32)) : mag_a;
      end else if (calc_step) begin
        cnt_q <= cnt_q - CW'(1);
        if (op_is_div(op_q)) begin
          rem_q <= rem_n;
          dvd_q <= {dvd_q[XLEN-2:0], q_bit};
        end else begin
          acc_q    <= acc_n;
          mcand_q  <= mc_n;
          mplier_q <= mp_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // XLEN=32 instance
  logic        start_a, kill_a, s32_a, busy_a, done_a;
  logic [2:0]  op_a;
  logic [31:0] rs1_a, rs2_a, res_a;

  // XLEN=64 instance
  logic        start_b, kill_b, s32_b, busy_b, done_b;
  logic [2:0]  op_b;
  logic [63:0] rs1_b, rs2_b, res_b;

  int tests_run = 0;
  int fails     = 0;

  muldiv_seq #(.XLEN(32), .ENABLE_DIV(1'b1), .MUL_UNROLL(1)) dut32 (
    .clock(clk), .reset(reset), .start(start_a), .kill(kill_a), .op(op_a),
    .s_32(s32_a), .rs1(rs1_a), .rs2(rs2_a), .busy(busy_a), .done(done_a),
    .result(res_a)
  );

  muldiv_seq #(.XLEN(64), .ENABLE_DIV(1'b1), .MUL_UNROLL(1)) dut64 (
    .clock(clk), .reset(reset), .start(start_b), .kill(kill_b), .op(op_b),
    .s_32(s32_b), .rs1(rs1_b), .rs2(rs2_b), .busy(busy_b), .done(done_b),
    .result(res_b)
  );

  // Reference model: exact arithmetic on wide signed integers.
  function automatic logic [63:0] model(input int xlen, input logic [2:0] op, input bit s32,
                                        input logic [63:0] a, input logic [63:0] b,
                                        output int lat);
    bit mulh, sa, sb, fast;
    int w;
    logic [129:0] ua, ub;
    logic signed [129:0] x, y, r, min_v;
    mulh = (op inside {3'd1, 3'd2, 3'd3});
    w    = (xlen == 32 || (s32 && !mulh)) ? 32 : 64;
    sa   = (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    sb   = (op inside {3'd0, 3'd1, 3'd4, 3'd6});
    if (w == 32) begin
      ua = sa ? {{98{a[31]}}, a[31:0]} : {98'b0, a[31:0]};
      ub = sb ? {{98{b[31]}}, b[31:0]} : {98'b0, b[31:0]};
    end else begin
      ua = sa ? {{66{a[63]}}, a} : {66'b0, a};
      ub = sb ? {{66{b[63]}}, b} : {66'b0, b};
    end
    x = $signed(ua);
    y = $signed(ub);
    case (op)
      3'd0:             r = x * y;
      3'd1, 3'd2, 3'd3: r = (x * y) >>> w;
      3'd4, 3'd5:       r = (y == 0) ? -130'sd1 : x / y;
      default:          r = (y == 0) ? x : x % y;
    endcase
    min_v = -(130'sd1 <<< (w - 1));
    fast  = op[2] && ((y == 0) || (sa && x == min_v && y == -130'sd1));
    lat   = fast ? 2 : w + 2;
    if (w == 32) return {{32{r[31]}}, r[31:0]};
    return r[63:0];
  endfunction

  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    start_a = 1'b1; op_a = op; rs1_a = a; rs2_a = b;
    @(negedge clk);
    start_a = 1'b0; op_a = 3'($urandom); rs1_a = $urandom; rs2_a = $urandom;
    lat = 1;
    while (done_a !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = res_a;
  endtask

  task automatic run64(input logic [2:0] op, input bit s32, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    @(negedge clk);
    start_b = 1'b1; op_b = op; s32_b = s32; rs1_b = a; rs2_b = b;
    @(negedge clk);
    start_b = 1'b0; op_b = 3'($urandom); s32_b = 1'($urandom);
    rs1_b = {$urandom, $urandom}; rs2_b = {$urandom, $urandom};
    lat = 1;
    while (done_b !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = res_b;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start_a = 0; kill_a = 0; s32_a = 0; op_a = 0; rs1_a = 0; rs2_a = 0;
    start_b = 0; kill_b = 0; s32_b = 0; op_b = 0; rs1_b = 0; rs2_b = 0;
    repeat (3) @(negedge clk);
    tests_run++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset busy32 got %b want 0", busy_a); end
    tests_run++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset done32 got %b want 0", done_a); end
    tests_run++; if (res_a !== 32'h0) begin fails++; $display("FAIL reset result32 got %h want 0", res_a); end
    tests_run++; if (busy_b !== 1'b0) begin fails++; $display("FAIL reset busy64 got %b want 0", busy_b); end
    tests_run++; if (done_b !== 1'b0) begin fails++; $display("FAIL reset done64 got %b want 0", done_b); end
    tests_run++; if (res_b !== 64'h0) begin fails++; $display("FAIL reset result64 got %h want 0", res_b); end
    reset = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
  } vec32_t;

  task automatic test_directed32;
    vec32_t v[$];
    logic [31:0] res;
    int lat;
    v.push_back('{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    v.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34});
    v.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34});
    v.push_back('{3'd5, 32'd100,      32'd7,        32'd14,        34});
    v.push_back('{3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 2});
    v.push_back('{3'd7, 32'd5,        32'd0,        32'd5,         2});
    v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
    v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2});
    foreach (v[i]) begin
      run32(v[i].op, v[i].a, v[i].b, res, lat);
      tests_run++;
      if (res !== v[i].exp) begin fails++; $display("FAIL dir32[%0d] result got %h want %h", i, res, v[i].exp); end
      tests_run++;
      if (lat != v[i].lat) begin fails++; $display("FAIL dir32[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_random32;
    logic [2:0] op;
    logic [31:0] a, b, res;
    logic [63:0] exp;
    int lat, elat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      exp = model(32, op, 1'b0, {32'h0, a}, {32'h0, b}, elat);
      run32(op, a, b, res, lat);
      tests_run++;
      if (res !== exp[31:0]) begin fails++; $display("FAIL rnd32[%0d] op%0d %h,%h got %h want %h", i, op, a, b, res, exp[31:0]); end
      tests_run++;
      if (lat != elat) begin fails++; $display("FAIL rnd32[%0d] latency got %0d want %0d", i, lat, elat); end
    end
  endtask

  task automatic test_word64;
    logic [2:0] op;
    bit s32;
    logic [63:0] a, b, res, exp;
    int lat, elat;
    run64(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, res, lat);
    tests_run++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin fails++; $display("FAIL mulw result got %h want fffffffffffffffe", res); end
    tests_run++; if (lat != 34) begin fails++; $display("FAIL mulw latency got %0d want 34", lat); end
    run64(3'd5, 1'b1, 64'hDEAD_0000_0000_0010, 64'd4, res, lat);
    tests_run++; if (res !== 64'd4) begin fails++; $display("FAIL divuw result got %h want 4", res); end
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom);
      s32 = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: a = s32 ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
        1: a[31:0] = $urandom_range(0, 50);
        default: ;
      endcase
      case ($urandom_range(0, 4))
        0: b = s32 ? {b[63:32], 32'h0} : 64'h0;
        1: b = s32 ? {b[63:32], 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        2: b[31:0] = $urandom_range(1, 9);
        default: ;
      endcase
      exp = model(64, op, s32, a, b, elat);
      run64(op, s32, a, b, res, lat);
      tests_run++;
      if (res !== exp) begin fails++; $display("FAIL rnd64[%0d] op%0d w%0d %h,%h got %h want %h", i, op, s32, a, b, res, exp); end
      tests_run++;
      if (lat != elat) begin fails++; $display("FAIL rnd64[%0d] latency got %0d want %0d", i, lat, elat); end
    end
  endtask

  task automatic test_kill;
    logic [31:0] res;
    int lat;
    run32(3'd5, 32'd100, 32'd7, res, lat);
    tests_run++; if (res !== 32'd14) begin fails++; $display("FAIL kill_pre result got %h want 14", res); end
    // kill beats start while idle
    @(negedge clk);
    start_a = 1'b1; kill_a = 1'b1; op_a = 3'd0; rs1_a = 32'd3; rs2_a = 32'd3;
    @(negedge clk);
    start_a = 1'b0; kill_a = 1'b0;
    tests_run++; if (busy_a !== 1'b0) begin fails++; $display("FAIL kill_vs_start busy got %b want 0", busy_a); end
    // kill in CALC cycle 10
    start_a = 1'b1; op_a = 3'd0; rs1_a = 32'd123; rs2_a = 32'd456;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    kill_a = 1'b1;
    @(negedge clk);
    kill_a = 1'b0;
    tests_run++; if (busy_a !== 1'b0) begin fails++; $display("FAIL kill busy got %b want 0", busy_a); end
    tests_run++; if (done_a !== 1'b0) begin fails++; $display("FAIL kill done got %b want 0", done_a); end
    tests_run++; if (res_a !== 32'd14) begin fails++; $display("FAIL kill result got %h want 0000000e", res_a); end
    // restart on the very next cycle
    start_a = 1'b1; op_a = 3'd4; rs1_a = 32'd1000; rs2_a = 32'hFFFF_FFFD;
    @(negedge clk);
    start_a = 1'b0;
    lat = 1;
    while (done_a !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    tests_run++; if (res_a !== 32'hFFFF_FEB3) begin fails++; $display("FAIL kill_restart result got %h want fffffeb3", res_a); end
    tests_run++; if (lat != 34) begin fails++; $display("FAIL kill_restart latency got %0d want 34", lat); end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    start_a = 1'b1; op_a = 3'd0; rs1_a = 32'd11; rs2_a = 32'd13;
    @(negedge clk);
    start_a = 1'b0;
    lat = 1;
    while (done_a !== 1'b1 && lat < 200) begin
      if (lat == 5) begin start_a = 1'b1; op_a = 3'd4; rs1_a = 32'd99; rs2_a = 32'd3; end
      else start_a = 1'b0;
      @(negedge clk);
      lat++;
    end
    start_a = 1'b0;
    tests_run++; if (res_a !== 32'd143) begin fails++; $display("FAIL busy_start result got %h want 0000008f", res_a); end
    tests_run++; if (lat != 34) begin fails++; $display("FAIL busy_start latency got %0d want 34", lat); end
    @(negedge clk);
    tests_run++; if (busy_a !== 1'b0) begin fails++; $display("FAIL busy_start queued busy got %b want 0", busy_a); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    start_a = 1'b1; op_a = 3'd0; rs1_a = 32'd6; rs2_a = 32'hFFFF_FFF9;
    @(negedge clk);
    start_a = 1'b0;
    lat = 1;
    while (done_a !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    tests_run++; if (res_a !== 32'hFFFF_FFD6) begin fails++; $display("FAIL b2b first result got %h want ffffffd6", res_a); end
    // start in the done cycle
    start_a = 1'b1; op_a = 3'd5; rs1_a = 32'd1000; rs2_a = 32'd10;
    @(negedge clk);
    start_a = 1'b0;
    lat = 1;
    while (done_a !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    tests_run++; if (res_a !== 32'd100) begin fails++; $display("FAIL b2b second result got %h want 00000064", res_a); end
    tests_run++; if (lat != 34) begin fails++; $display("FAIL b2b second latency got %0d want 34", lat); end
  endtask

  task automatic test_midop_reset;
    @(negedge clk);
    start_a = 1'b1; op_a = 3'd0; rs1_a = 32'd9; rs2_a = 32'd9;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (busy_a !== 1'b0) begin fails++; $display("FAIL midreset busy got %b want 0", busy_a); end
    tests_run++; if (done_a !== 1'b0) begin fails++; $display("FAIL midreset done got %b want 0", done_a); end
    tests_run++; if (res_a !== 32'h0) begin fails++; $display("FAIL midreset result got %h want 0", res_a); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed32();
    test_random32();
    test_word64();
    test_kill();
    test_start_while_busy();
    test_back_to_back();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative, multi-cycle M-extension unit that replaces the combinational mul/div path in the EX stage.
- Parametrised in XLEN, with RV64 word-op (s_32) support, selectable multiply unrolling, and a start/busy/done handshake.
- The hazard unit holds the front of the pipe while the unit is busy and bubbles EX→MEM until done.
- A kill input aborts an in-flight operation when EX is flushed.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- ENABLE_DIV, 1, 0 = div/rem ops take the fast path and return 0.
- MUL_UNROLL, 1, multiply bits retired per CALC cycle (1, 2 or 4); must divide 32.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  launch request, sampled only in IDLE.
- kill  in  1  synchronous abort of any operation.
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- s_32  in  1  RV64 word op; ignored when XLEN=32.
- rs1  in  XLEN  operand A (dividend / multiplicand).
- rs2  in  XLEN  operand B (divisor / multiplier).
- busy  out  1  state != IDLE.
- done  out  1  registered, one-cycle pulse; result valid.
- result  out  XLEN  registered result, held until the next done.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
- FSM states and transitions:
  - IDLE→CALC when start=1, kill=0 and the fast path does not apply; operands, op and s_32 are latched on that edge.
  - IDLE→FIX on start when the fast path applies.
  - CALC→FIX after N iterations.
  - FIX→IDLE, loading result and setting done=1 on the same edge.
- done is cleared on the following edge. busy is not combinationally dependent on start.
- Iteration count N:
  - Multiply: W/MUL_UNROLL cycles.
  - Divide: W cycles (restoring, 1 quotient bit per cycle).
  - W = 32 if (s_32 and XLEN=64), else XLEN.
- Latency: done is high N+2 cycles after the start cycle; the fast path gives 2 cycles.
- Operand preparation (word ops, XLEN=64, s_32=1):
  - Use the low 32 bits of rs1 and rs2.
  - Signed ops sign-extend from bit 31; unsigned ops zero-extend.
  - The final result is low32 sign-extended to 64.
- MULH/MULHSU/MULHU with s_32=1 execute as full-width ops; s_32 is ignored for them.
- Multiply:
  - Magnitudes are multiplied unsigned into a 2W-bit product.
  - FIX negates the product if the operand signs differ; signedness per op (MULHSU: rs1 signed, rs2 unsigned).
  - MUL returns the low W bits; MULH* return the high W bits.
- Divide:
  - Magnitudes go through the restoring divider.
  - FIX sets sign(q) = sign(a) XOR sign(b) and sign(r) = sign(a); signed ops only.
- Fast path (resolved at start, no CALC), defined against W-bit operands:
  - Divisor 0: DIV/DIVU q = all ones; REM/REMU r = rs1.
  - Signed overflow (a = -2^(W-1), b = -1): DIV q = a; REM r = 0.
  - ENABLE_DIV=0 with op ≥ 4: result = 0.
- Handshake and boundary conditions:
  - start while busy=1 is ignored; no queueing.
  - start in the same cycle as done=1 is accepted, since state is IDLE.
  - kill=1: next edge state=IDLE; done is not asserted; result keeps its old value.
  - kill has priority over start in the same cycle.
  - Reset mid-operation behaves as kill and also clears result.
  - Operand inputs may change after the start cycle; only the latched copies are used.

Decomposition:
- Op-code constants (MD_MUL … MD_REMU) and the alu_op[4:2] group codes (3'b100 mul, 3'b101 div) go in defines.vh.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder and quotient bit.
- Instantiated once, or MUL-style unrolled later.
- Multiplier shift-add and FSM stay in muldiv_seq.

Test Plan:
- XLEN=32, MUL_UNROLL=1: MUL 7×(-3) → done at cycle 34 after start, result=0xFFFFFFEB; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV -7/2 → q=0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; latency 34 cycles.
- Fast path:
  - DIV 5/0 → 0xFFFFFFFF in 2 cycles.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- XLEN=64, s_32=1:
  - MUL rs1=0x00000000_7FFFFFFF, rs2=2 → 0xFFFFFFFF_FFFFFFFE, done after 34 cycles.
  - DIVU s_32 with rs1=0xDEAD0000_00000010, rs2=4 → 4.
- kill asserted at CALC cycle 10 → busy=0 next cycle, no done, result unchanged; a new start the following cycle completes normally.
- start pulsed while busy → ignored; back-to-back start on the done cycle → second result arrives N+2 cycles later. Mid-op reset=0 → busy=0, done=0, result=0.
